// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

    localparam int          FQ_ADDR_W  = 8;
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INST_NOP   = 32'h00000033;

    typedef struct packed {
        logic [FQ_ADDR_W-1:0] pc;
        logic [31:0]          inst;
    } fetch_entry_t;

    typedef enum logic {
        FQ_RUN,
        FQ_HALT
    } fq_state_t;

    function automatic logic is_system(input logic [31:0] word);
        return word[6:0] == OPC_SYSTEM;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush and push/pop-at-full support.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  fetch_entry_t       push_data,
    output fetch_entry_t       head,
    output logic [LVL_W-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: drives fetch address, buffers {pc, inst}, halts on SYSTEM.
// Optional FETCH_BYPASS_EN adds a zero-latency memory-to-decode path when the queue is empty.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter int               ADDR_W   = FQ_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [31:0]                mem_rdata,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                inst,
    output logic [ADDR_W-1:0]          inst_pc,
    output logic                       halted,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    fq_state_t         state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    fetch_entry_t      head;
    fetch_entry_t      tail;
    logic              empty;
    logic              fifo_pop;
    logic              fifo_push;
    logic              bypass;

    assign empty    = (level == '0);
    assign fifo_pop = ~empty & inst_ready & ~redirect;
    assign mem_req  = rst & (state == FQ_RUN) & ~redirect
                    & ((level < LVL_W'(DEPTH)) | fifo_pop);
    assign mem_addr = fetch_pc;

`ifdef FETCH_BYPASS_EN
    assign bypass = mem_req & empty & inst_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word goes straight to decode and never occupies a slot.
    assign fifo_push = mem_req & ~bypass;
    assign tail      = '{pc: fetch_pc, inst: mem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (tail),
        .head      (head),
        .level     (level)
    );

    assign inst_valid = (~empty & ~redirect) | bypass;
    assign inst       = bypass ? mem_rdata : (empty ? INST_NOP : head.inst);
    assign inst_pc    = bypass ? mem_addr  : (empty ? '0 : head.pc);
    assign halted     = (state == FQ_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FQ_RUN;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect)     fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            else if (mem_req) fetch_pc <= fetch_pc + ADDR_W'(4);
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect)                             state_nxt = FQ_RUN;
        else if (mem_req && is_system(mem_rdata)) state_nxt = FQ_HALT;
    end

endmodule
